// File: rtl/dmem_sequencer_pkg.sv
// Shared types and helpers for the MEM-stage data-memory sequencer:
// FSM state encoding, load/store funct3 codes and byte-lane helpers.
package dmem_pkg;

  localparam int BE_W = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } dmem_state_e;

  // Codes outside the b/h/bu/hu set behave as word accesses.
  function automatic logic access_aligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B, F3_BU: access_aligned = 1'b1;
      F3_H, F3_HU: access_aligned = ~off[0];
      default:     access_aligned = (off == 2'b00);
    endcase
  endfunction

  function automatic logic [BE_W-1:0] store_be(input logic we, input logic [2:0] f3,
                                               input logic [1:0] off);
    if (!we) begin
      store_be = 4'b1111;
    end else begin
      case (f3)
        F3_B, F3_BU: store_be = 4'b0001 << off;
        F3_H, F3_HU: store_be = 4'b0011 << off;
        default:     store_be = 4'b1111;
      endcase
    end
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      F3_B, F3_BU: store_wdata = {4{wd[7:0]}};
      F3_H, F3_HU: store_wdata = {2{wd[15:0]}};
      default:     store_wdata = wd;
    endcase
  endfunction

endpackage

// File: rtl/dmem_sequencer_if.sv
// Request/acknowledge bus between the MEM-stage sequencer (master) and data memory (slave).
interface dmem_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic                      dmem_req;
  logic                      dmem_we;
  logic [ADDR_W-1:0]         dmem_addr;
  logic [dmem_pkg::BE_W-1:0] dmem_be;
  logic [31:0]               dmem_wdata;
  logic                      dmem_ack;
  logic [31:0]               dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/dmem_sequencer_load_extend.sv
// Load-data lane select plus sign/zero extension for b/h/bu/hu; words pass through.
module load_extend
  import dmem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[{offset, 3'b000} +: 8];
    half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    result = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   result = {24'd0, byte_lane};
      F3_H:    result = {{16{half_lane[15]}}, half_lane};
      F3_HU:   result = {16'd0, half_lane};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_sequencer.sv
// MEM-stage load/store sequencer: stalls the pipeline across a variable-latency req/ack access.
// Define DMEM_TIMEOUT_EN to abort REQ with a bus_error pulse after TIMEOUT cycles without ack.
module dmem_sequencer
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mreq,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              flush,
  dmem_sequencer_if.master  dmem,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              misaligned,
  output logic              bus_error
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_REQ  = ST_REQ;
  localparam logic [1:0] S_DONE = ST_DONE;

  logic [1:0]        state;
  logic              drop;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [BE_W-1:0]   req_be;
  logic [31:0]       req_wdata;
  logic [2:0]        req_f3;
  logic [1:0]        req_off;
  logic [31:0]       rdata_q;
  logic [31:0]       load_word;
  logic              in_req;
  logic              is_aligned;
  logic              start;
  logic              timeout_hit;

  assign in_req     = (state == S_REQ);
  assign is_aligned = access_aligned(funct3, addr[1:0]);
  assign start      = (state == S_IDLE) & mreq & ~flush & is_aligned;
  assign misaligned = (state == S_IDLE) & mreq & ~flush & ~is_aligned;

  load_extend u_load_extend (
    .rdata  (dmem.dmem_rdata),
    .offset (req_off),
    .funct3 (req_f3),
    .result (load_word)
  );

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] wait_cnt;
  logic             bus_err_q;

  assign timeout_hit = in_req & ~dmem.dmem_ack & (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign bus_error   = bus_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= timeout_hit;
      wait_cnt  <= in_req ? wait_cnt + 1'b1 : '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign bus_error   = 1'b0;
`endif

  // A squashed access still has to finish on the bus; drop only suppresses its result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      drop      <= 1'b0;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_be    <= '0;
      req_wdata <= '0;
      req_f3    <= '0;
      req_off   <= '0;
      rdata_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_REQ;
            drop      <= 1'b0;
            req_we    <= mem_write;
            req_addr  <= {addr[ADDR_W-1:2], 2'b00};
            req_be    <= store_be(mem_write, funct3, addr[1:0]);
            req_wdata <= mem_write ? store_wdata(funct3, wdata) : 32'd0;
            req_f3    <= funct3;
            req_off   <= addr[1:0];
          end
        end
        S_REQ: begin
          if (flush) drop <= 1'b1;
          if (dmem.dmem_ack) begin
            if (!req_we && !drop && !flush) rdata_q <= load_word;
            state <= (drop || flush) ? S_IDLE : S_DONE;
            drop  <= 1'b0;
          end else if (timeout_hit) begin
            state <= S_IDLE;
            drop  <= 1'b0;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dmem.dmem_req   = in_req;
  assign dmem.dmem_we    = in_req & req_we;
  assign dmem.dmem_addr  = in_req ? req_addr : '0;
  assign dmem.dmem_be    = in_req ? req_be : '0;
  assign dmem.dmem_wdata = in_req ? req_wdata : 32'd0;

  assign stall       = start | in_req;
  assign rdata_valid = (state == S_DONE);
  assign rdata       = rdata_q;

endmodule
